// File: rtl/booth_dot_acc.sv
// Saturating dot-product accumulator behind the Booth multiplier.
// Sums LEN signed products per group and holds each result until the consumer takes it.
module booth_dot_acc #(
  parameter int unsigned N   = 5,
  parameter int unsigned AW  = 16,
  parameter int unsigned LEN = 4,
  localparam int unsigned CW = $clog2(LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            prod_valid,
  output logic            prod_ready,
  input  logic [2*N-1:0]  product,
  output logic            acc_valid,
  input  logic            acc_ready,
  output logic [AW-1:0]   acc_out,
  output logic            sat_flag,
  output logic [CW-1:0]   count
);

  if (AW < 2 * N) begin : g_aw_check
    $error("booth_dot_acc: AW must be at least 2*N");
  end
  if (LEN < 1) begin : g_len_check
    $error("booth_dot_acc: LEN must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  localparam logic [CW-1:0] LenC = CW'(LEN);

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            sat_q, sat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;

  logic            accept;
  logic [AW:0]     acc_ext, prod_ext, sum;
  logic            ovf;
  logic [AW-1:0]   acc_sat;
  logic [CW-1:0]   cnt_inc;

  assign prod_ready = (state_q != StDone) && !clr;
  assign accept     = prod_valid && prod_ready;

  // One guard bit: overflow shows up as disagreement between the top two sum bits.
  assign acc_ext  = {acc_q[AW-1], acc_q};
  assign prod_ext = {{(AW + 1 - 2 * N){product[2*N-1]}}, product};
  assign sum      = acc_ext + prod_ext;
  assign ovf      = sum[AW] ^ sum[AW-1];
  assign acc_sat  = !ovf    ? sum[AW-1:0] :
                    sum[AW] ? {1'b1, {(AW - 1){1'b0}}} :
                              {1'b0, {(AW - 1){1'b1}}};
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clr) begin
      state_d = StIdle;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == StDone) begin
      if (acc_ready) begin
        state_d = StIdle;
        acc_d   = '0;
        sat_d   = 1'b0;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    end else if (accept) begin
      acc_d = acc_sat;
      sat_d = sat_q | ovf;
      cnt_d = cnt_inc;
      if (cnt_inc == LenC) begin
        state_d = StDone;
        valid_d = 1'b1;
      end else begin
        state_d = StAcc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign acc_valid = valid_q;
  assign acc_out   = acc_q;
  assign sat_flag  = sat_q;
  assign count     = cnt_q;

endmodule

// File: doc/booth_dot_acc.md
# booth_dot_acc

Downstream accumulation stage for the Booth multiplier. Consumes signed products over a valid/ready handshake, sums groups of LEN products into a saturating signed accumulator, and presents each completed dot product over a second valid/ready handshake. Sits between the multiplier's product output and the result consumer.

## Interface
- N, 5: multiplier operand width; products are 2N bits, two's complement
- AW, 16: accumulator/result width; AW >= 2N required, enforced by an elaboration/sim-time check
- LEN, 4: products per dot product; LEN >= 1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the current group
- prod_valid  in  1  product present
- prod_ready  out  1  stage can accept a product
- product  in  2N  signed product
- acc_valid  out  1  completed dot product present
- acc_ready  in  1  consumer accepts the result
- acc_out  out  AW  signed accumulator register
- sat_flag  out  1  sticky: saturation occurred in the current group
- count  out  $clog2(LEN+1)  products accepted in the current group

## Operation
- States: IDLE (count==0), ACC (0<count<LEN), DONE (result held).
- prod_ready = (state != DONE) && !clr; combinational. It reads 1 while rst is low, but no register updates during reset.
- Accept occurs when prod_valid && prod_ready.
- On accept:
  - sign-extend product to AW+1 bits and add to sign-extended acc_out;
  - if the sum exceeds 2^(AW-1)-1, load that value and set sat_flag;
  - if the sum is below -2^(AW-1), load -2^(AW-1) and set sat_flag;
  - otherwise load the sum;
  - count increments.
- Transitions:
  - IDLE -> ACC on accept when LEN > 1.
  - IDLE or ACC -> DONE on the accept that makes count == LEN. acc_valid is set in the same edge.
  - DONE -> IDLE on acc_valid && acc_ready. In that edge acc_out, count and sat_flag clear to 0 and acc_valid drops.
- In DONE: acc_out, sat_flag and count == LEN are held stable, and no product is accepted.
- Saturation is clamp-and-continue. Later additions use the clamped value, so the sum can move back off the rail. sat_flag stays set until the group ends.
- clr (synchronous, any state): zero acc_out, count, sat_flag and acc_valid; go to IDLE. A product offered in that cycle is not accepted, because prod_ready is 0.
- Priority: rst > clr > result handshake > product accept.

## Timing
- Reset values: acc_out=0, acc_valid=0, sat_flag=0, count=0, state IDLE.
- Reset mid-group or in DONE discards all partial or held results immediately (asynchronous).
- Throughput: one product per cycle in IDLE/ACC.
- Latency: acc_valid is high the cycle after the LEN-th accept edge, i.e. registered.
- The earliest new product accept is the cycle after the result handshake edge. A group therefore occupies at least LEN+1 cycles.
- Gaps in prod_valid stall accumulation without effect; count and acc_out hold.
- acc_ready is ignored outside DONE.
- acc_out is visible as a running sum during ACC. It is only a valid result while acc_valid is high.

## Test plan
- Reset:
  - Drive rst low mid-group: acc_out=0, count=0, acc_valid=0, sat_flag=0 without waiting for a clock edge.
  - Release rst, then offer a product: accepted on the first edge.
- Basic group (defaults):
  - Stimulus: four back-to-back products of -70 (10'h3BA, i.e. 14 × -5).
  - Required: count 1,2,3,4; acc_out=16'hFEE8 (-280); acc_valid high the cycle after the 4th accept; sat_flag=0.
- Saturation (override AW=10):
  - Stimulus: products 256, 256, -100, 0.
  - After 2nd: acc_out=511, sat_flag=1.
  - Final: acc_out=411, sat_flag=1.
  - Repeat with four products of -256: final acc_out=-512.
- Backpressure:
  - Hold acc_ready low 5 cycles in DONE with prod_valid high: acc_out, acc_valid and count=4 stable; prod_ready=0; no accept.
  - Raise acc_ready: next cycle IDLE, acc_out=0, and the pending product is accepted the following edge.
- Gaps and clr:
  - Products 10, gap, 20, then clr together with a valid product 30: acc_out=0, count=0, and 30 is not accepted.
  - Next group 1,2,3,4 gives acc_out=10.
- LEN=1 override:
  - Each accept goes directly to DONE.
  - Product -512 gives acc_out=16'hFE00 with acc_valid the next cycle.
